// File: rtl/bt_cmd_parser.sv
// ASCII command parser for the pan/tilt tracker: decodes A/M/P/T frames
// from a UART byte stream into mode and angle setpoints.
module bt_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned MAX_ANGLE      = 180,
  parameter int unsigned DEFAULT_ANGLE  = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       mode_auto,
  output logic [7:0] pan_angle,
  output logic [7:0] tilt_angle,
  output logic       cmd_strobe,
  output logic [1:0] cmd_code,
  output logic       cmd_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CODE_A = 2'd0;
  localparam logic [1:0] CODE_M = 2'd1;
  localparam logic [1:0] CODE_P = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_LF = 2'd1,
    S_DIGITS  = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mode_auto_q, mode_auto_d;
  logic [7:0]    pan_q, pan_d;
  logic [7:0]    tilt_q, tilt_d;
  logic [1:0]    code_q, code_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;
  logic [1:0]    pend_q, pend_d;
  logic [9:0]    acc_q, acc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic is_cr, byte_v, is_lf, is_digit;
  logic [3:0] digit;

  assign is_cr    = rx_valid && (rx_byte == 8'h0D);
  assign byte_v   = rx_valid && !is_cr;
  assign is_lf    = (rx_byte == 8'h0A);
  assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign digit    = rx_byte[3:0];

  // Next-state, frame decode, apply and timeout logic
  always_comb begin
    state_d     = state_q;
    mode_auto_d = mode_auto_q;
    pan_d       = pan_q;
    tilt_d      = tilt_q;
    code_d      = code_q;
    strobe_d    = 1'b0;
    err_d       = 1'b0;
    pend_d      = pend_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;

    if (byte_v) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_byte == "A" || rx_byte == "M") begin
            pend_d  = (rx_byte == "A") ? CODE_A : CODE_M;
            state_d = S_WAIT_LF;
          end else if (rx_byte == "P" || rx_byte == "T") begin
            pend_d  = (rx_byte == "P") ? CODE_P : 2'd3;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_DIGITS;
          end else if (!is_lf) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_WAIT_LF: begin
          if (is_lf) begin
            code_d      = pend_q;
            strobe_d    = 1'b1;
            mode_auto_d = (pend_q == CODE_A);
            state_d     = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_DIGITS: begin
          if (is_digit && cnt_q != 2'd3) begin
            acc_d = acc_q * 10'd10 + {6'b0, digit};
            cnt_d = cnt_q + 2'd1;
          end else if (is_lf) begin
            state_d = S_IDLE;
            if (cnt_q == 2'd0 || acc_q > 10'(MAX_ANGLE) || mode_auto_q) begin
              err_d = 1'b1;
            end else begin
              code_d   = pend_q;
              strobe_d = 1'b1;
              if (pend_q == CODE_P) pan_d = acc_q[7:0];
              else                  tilt_d = acc_q[7:0];
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (is_lf) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // CR bytes fall through here too, so they never restart the timeout
      if (tmo_q >= TMO_LAST) begin
        tmo_d   = '0;
        state_d = S_IDLE;
        err_d   = (state_q != S_DISCARD);
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_auto_q <= 1'b1;
      pan_q       <= 8'(DEFAULT_ANGLE);
      tilt_q      <= 8'(DEFAULT_ANGLE);
      code_q      <= '0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_auto_q <= mode_auto_d;
      pan_q       <= pan_d;
      tilt_q      <= tilt_d;
      code_q      <= code_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mode_auto  = mode_auto_q;
  assign pan_angle  = pan_q;
  assign tilt_angle = tilt_q;
  assign cmd_code   = code_q;
  assign cmd_strobe = strobe_q;
  assign cmd_error  = err_q;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Self-checking bench for bt_cmd_parser: expected strobe/error events are
// queued as frames are sent and matched by a monitor as pulses appear.
module tb_bt_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       mode_auto, cmd_strobe, cmd_error;
  logic [7:0] pan_angle, tilt_angle;
  logic [1:0] cmd_code;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_fail = 0;
  int  n_err_seen = 0;

  bt_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .mode_auto(mode_auto), .pan_angle(pan_angle), .tilt_angle(tilt_angle),
    .cmd_strobe(cmd_strobe), .cmd_code(cmd_code), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every pulse must match the next queued event
  always @(negedge clk) begin
    if (rst_n && (cmd_strobe || cmd_error)) begin
      ev_t e;
      if (cmd_error) n_err_seen++;
      n_vec++;
      if (cmd_strobe && cmd_error) begin
        n_fail++;
        $display("FAIL pulse_overlap: strobe=%b error=%b required not both", cmd_strobe, cmd_error);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: strobe=%b error=%b code=%0d required none", cmd_strobe, cmd_error, cmd_code);
      end else begin
        e = exp_q.pop_front();
        if (cmd_error !== e.is_err || (!e.is_err && cmd_code !== e.code)) begin
          n_fail++;
          $display("FAIL event: error=%b code=%0d required error=%b code=%0d", cmd_error, cmd_code, e.is_err, e.code);
        end
      end
    end
  end

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = $urandom_range(255);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_ev(input logic is_err, input logic [1:0] code);
    ev_t e;
    e.is_err = is_err;
    e.code   = code;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_events: outstanding=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({mode_auto, pan_angle, tilt_angle, cmd_code, cmd_strobe, cmd_error} !==
        {1'b1, 8'd90, 8'd90, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: mode=%b pan=%0d tilt=%0d code=%0d strb=%b err=%b required 1 90 90 0 0 0",
               mode_auto, pan_angle, tilt_angle, cmd_code, cmd_strobe, cmd_error);
    end
  endtask

  task automatic test_manual_pan();
    expect_ev(1'b0, 2'd1);
    expect_ev(1'b0, 2'd2);
    send_str("M\n");
    send_str("P135\n");
    drain("manual_pan");
    n_vec++;
    if ({mode_auto, pan_angle, tilt_angle, cmd_code} !== {1'b0, 8'd135, 8'd90, 2'd2}) begin
      n_fail++;
      $display("FAIL manual_pan: mode=%b pan=%0d tilt=%0d code=%0d required 0 135 90 2",
               mode_auto, pan_angle, tilt_angle, cmd_code);
    end
    expect_ev(1'b0, 2'd1);
    expect_ev(1'b0, 2'd1);
    send_str("M\nM\n");
    drain("repeat_m");
  endtask

  task automatic test_tilt_range();
    expect_ev(1'b1, 2'd0);
    send_str("T181\n");
    drain("tilt_181");
    n_vec++;
    if (tilt_angle !== 8'd90) begin
      n_fail++;
      $display("FAIL tilt_181: tilt=%0d required 90", tilt_angle);
    end
    expect_ev(1'b0, 2'd3);
    send_str("T");
    send_byte(8'h0D);
    send_str("180");
    send_byte(8'h0D);
    send_str("\n");
    drain("tilt_cr");
    n_vec++;
    if (tilt_angle !== 8'd180 || cmd_code !== 2'd3) begin
      n_fail++;
      $display("FAIL tilt_cr: tilt=%0d code=%0d required 180 3", tilt_angle, cmd_code);
    end
    expect_ev(1'b0, 2'd2);
    expect_ev(1'b0, 2'd2);
    send_str("P180\n");
    send_str("P0\n");
    drain("pan_bounds");
    n_vec++;
    if (pan_angle !== 8'd0) begin
      n_fail++;
      $display("FAIL pan_zero: pan=%0d required 0", pan_angle);
    end
    expect_ev(1'b1, 2'd0);
    send_str("P\n");
    drain("pan_nodigits");
  endtask

  task automatic test_auto_reject();
    do_reset();
    expect_ev(1'b1, 2'd0);
    send_str("P045\n");
    drain("auto_reject");
    n_vec++;
    if (pan_angle !== 8'd90) begin
      n_fail++;
      $display("FAIL auto_reject: pan=%0d required 90", pan_angle);
    end
    expect_ev(1'b0, 2'd0);
    send_str("A\n");
    drain("auto_a");
    n_vec++;
    if (cmd_code !== 2'd0 || mode_auto !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_a: code=%0d mode=%b required 0 1", cmd_code, mode_auto);
    end
  endtask

  task automatic test_errors();
    expect_ev(1'b0, 2'd1);
    send_str("M\n");
    expect_ev(1'b1, 2'd0);
    send_str("X12\n");
    expect_ev(1'b1, 2'd0);
    send_str("P1234\n");
    expect_ev(1'b0, 2'd2);
    send_str("P10\n");
    drain("errors");
    n_vec++;
    if (pan_angle !== 8'd10) begin
      n_fail++;
      $display("FAIL errors_pan: pan=%0d required 10", pan_angle);
    end
  endtask

  task automatic test_timeout();
    int base;
    expect_ev(1'b1, 2'd0);
    send_str("P4");
    base = n_err_seen;
    repeat (90) @(negedge clk);
    n_vec++;
    if (n_err_seen != base) begin
      n_fail++;
      $display("FAIL timeout_early: errors=%0d required %0d", n_err_seen - base, 0);
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (n_err_seen != base + 1) begin
      n_fail++;
      $display("FAIL timeout_fire: errors=%0d required %0d", n_err_seen - base, 1);
    end
    expect_ev(1'b1, 2'd0);
    send_str("5\n");
    drain("timeout_tail");
    n_vec++;
    if (pan_angle !== 8'd10) begin
      n_fail++;
      $display("FAIL timeout_pan: pan=%0d required 10", pan_angle);
    end
  endtask

  task automatic test_reset_midframe();
    expect_ev(1'b0, 2'd1);
    send_str("M\n");
    send_str("P12");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mode_auto, pan_angle, tilt_angle, cmd_code, cmd_strobe, cmd_error} !==
        {1'b1, 8'd90, 8'd90, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midframe_reset: mode=%b pan=%0d tilt=%0d code=%0d required 1 90 90 0",
               mode_auto, pan_angle, tilt_angle, cmd_code);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_ev(1'b1, 2'd0);
    send_str("P12\n");
    drain("midframe_after");
    n_vec++;
    if (pan_angle !== 8'd90) begin
      n_fail++;
      $display("FAIL midframe_pan: pan=%0d required 90", pan_angle);
    end
  endtask

  initial begin
    test_reset();
    test_manual_pan();
    test_tilt_range();
    test_auto_reject();
    test_errors();
    test_timeout();
    do_reset();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
